// File: rtl/btn_debounce_pulse_pkg.sv
// rtl/btn_debounce_pulse_pkg.sv - shared types and constants for the button debounce front-end
//
// Purpose : debounce FSM state encoding, bounce counter geometry and the
//           saturating increment used by every channel.
// Ports   : none (package).

package btn_debounce_pulse_pkg;

  // Debounce FSM states. IDLE/ARM report level 0, PRESSED/DISARM report level 1.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    DISARM  = 2'd3
  } deb_state_t;

  localparam int                 BOUNCE_W   = 8;
  localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = 8'hFF;

  // Saturating +1 for the diagnostic bounce counter; it sticks at BOUNCE_MAX
  // so a long bring-up session never wraps back to a misleading small number.
  function automatic logic [BOUNCE_W-1:0] bounce_inc(input logic [BOUNCE_W-1:0] value);
    if (value == BOUNCE_MAX) begin
      return value;
    end
    return value + 8'd1;
  endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// rtl/btn_debounce_pulse_if.sv - button bundle between board pins and the debounce front-end
//
// Purpose : groups the raw button inputs with the cleaned level, press/release
//           strobes and diagnostic bounce counters.
// Signals : btn_raw        raw asynchronous button levels, 1 = pressed
//           btn_level      debounced level per channel
//           btn_pulse      one-cycle strobe on accepted press
//           btn_rel_pulse  one-cycle strobe on accepted release
//           bounce_cnt     per-channel saturating rejected-transition count,
//                          channel i in [8i+7:8i]
// Modports: master drives btn_raw and observes the rest (board/bench side);
//           slave is the debounce block.

interface btn_debounce_pulse_if
  import btn_debounce_pulse_pkg::*;
#(
  parameter int N_BTN = 2
);

  logic [N_BTN-1:0]          btn_raw;
  logic [N_BTN-1:0]          btn_level;
  logic [N_BTN-1:0]          btn_pulse;
  logic [N_BTN-1:0]          btn_rel_pulse;
  logic [BOUNCE_W*N_BTN-1:0] bounce_cnt;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  btn_rel_pulse,
    input  bounce_cnt
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output btn_rel_pulse,
    output bounce_cnt
  );

endinterface

// File: rtl/btn_debounce_pulse_debounce_chan.sv
// rtl/btn_debounce_pulse_debounce_chan.sv - single-channel synchroniser, debounce FSM and bounce counter
//
// Purpose : cleans one raw push-button into a stable level plus one-cycle
//           press/release strobes; counts rejected transitions.
// Ports   : clk         system clock, rising edge
//           clr         synchronous active-high reset
//           raw         raw asynchronous button level, 1 = pressed
//           level       debounced level (registered)
//           pulse       one-cycle strobe on accepted press (registered)
//           rel_pulse   one-cycle strobe on accepted release (registered)
//           bounce_cnt  saturating count of rejected transitions

module debounce_chan
  import btn_debounce_pulse_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                raw,
  output logic                level,
  output logic                pulse,
  output logic                rel_pulse,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  // Counter only has to reach STABLE_CYCLES-1, so clog2 of the threshold is enough.
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic s1;
  logic s2;

  deb_state_t          state;
  deb_state_t          state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nx;
  logic                level_nx;
  logic                pulse_nx;
  logic                rel_pulse_nx;
  logic [BOUNCE_W-1:0] bounce_nx;

  // Two-flop synchroniser; the FSM only ever looks at s2.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      level      <= 1'b0;
      pulse      <= 1'b0;
      rel_pulse  <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      level      <= level_nx;
      pulse      <= pulse_nx;
      rel_pulse  <= rel_pulse_nx;
      bounce_cnt <= bounce_nx;
    end
  end

  // ARM/DISARM count how many consecutive samples disagree with the current
  // level. Entering them already counts the first disagreeing sample, hence
  // cnt=1 on entry and acceptance when the last of STABLE_CYCLES agrees.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    level_nx     = level;
    pulse_nx     = 1'b0;
    rel_pulse_nx = 1'b0;
    bounce_nx    = bounce_cnt;

    case (state)
      IDLE: begin
        if (s2) begin
          state_nx = ARM;
          cnt_nx   = CNT_ONE;
        end
      end

      ARM: begin
        if (!s2) begin
          state_nx  = IDLE;
          cnt_nx    = '0;
          bounce_nx = bounce_inc(bounce_cnt);
        end else if (cnt == CNT_LAST) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          level_nx = 1'b1;
          pulse_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!s2) begin
          state_nx = DISARM;
          cnt_nx   = CNT_ONE;
        end
      end

      DISARM: begin
        if (s2) begin
          // Bounce back to pressed: the level never dropped, so no strobe.
          state_nx  = PRESSED;
          cnt_nx    = '0;
          bounce_nx = bounce_inc(bounce_cnt);
        end else if (cnt == CNT_LAST) begin
          state_nx     = IDLE;
          cnt_nx       = '0;
          level_nx     = 1'b0;
          rel_pulse_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        level_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - multi-channel push-button debounce and request-strobe front-end
//
// Purpose : per-channel debounce of raw buttons feeding the FIFO stage;
//           btn_pulse[0] drives button_wrd, btn_pulse[1] drives button_red.
// Ports   : clk  system clock, rising edge
//           clr  synchronous active-high reset
//           btn  slave side of btn_debounce_pulse_if (raw in; level,
//                strobes and packed bounce counters out)

module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int N_BTN         = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  btn_debounce_pulse_if.slave   btn
);

  // Channels are fully independent; coincident strobes pass straight through.
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .clr        (clr),
      .raw        (btn.btn_raw[i]),
      .level      (btn.btn_level[i]),
      .pulse      (btn.btn_pulse[i]),
      .rel_pulse  (btn.btn_rel_pulse[i]),
      .bounce_cnt (btn.bounce_cnt[BOUNCE_W*i +: BOUNCE_W])
    );
  end

endmodule
